// File: rtl/key_hex_driver.sv
// key_hex_driver
// Display-side controller for the six hex digits of the ARC4 cracker board.
// It tracks the crack engine's lifecycle (idle, searching, found, failed) and
// drives six registered nibbles plus a per-digit blank mask.
// While searching, it shows a periodically sampled snapshot of the candidate key.
// When the search ends, it shows the recovered key, or blanks the display on failure.
// All outputs come from registers, so the downstream decoders never see a glitch cycle.

module key_hex_driver #(
  parameter int SAMPLE_DIV = 2**20,  // cycles between candidate snapshots (>= 2)
  parameter int SAMPLE_W   = 20,     // counter width, 2**SAMPLE_W >= SAMPLE_DIV
  parameter bit LZ_BLANK   = 1'b1    // blank leading zero digits of the held key
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cand_key,
  input  logic        done,
  input  logic        key_valid,
  input  logic [23:0] key,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  hex4,
  output logic [3:0]  hex5,
  output logic [5:0]  blank,
  output logic        busy,
  output logic        found,
  output logic        failed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FOUND = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  // Counter value on the cycle just before a snapshot edge.
  localparam logic [SAMPLE_W-1:0] CNT_LAST  = SAMPLE_W'(SAMPLE_DIV - 1);
  localparam logic [SAMPLE_W-1:0] CNT_ONE   = SAMPLE_W'(1);
  localparam logic [5:0]          BLANK_ALL = 6'h3F;

  state_t              r_state;
  logic [23:0]         r_disp;
  logic [SAMPLE_W-1:0] r_cnt;
  logic [5:0]          r_blank;
  logic                r_busy;
  logic                r_found;
  logic                r_failed;

  // w_zero_from[n] is 1 when nibbles n..5 of the incoming key are all zero.
  // Digit 0 is never blanked, so a zero key still shows a single "0".
  logic [6:1]          w_zero_from;
  logic [5:0]          w_key_blank;
  logic                w_wrap;

  assign w_zero_from[6] = 1'b1;

  generate
    for (genvar gi = 1; gi < 6; gi++) begin : g_lz
      assign w_zero_from[gi] = w_zero_from[gi+1] & ~(|key[4*gi +: 4]);
    end
  endgenerate

  // The mask is built from the key input itself.
  // This lets it be registered on the same edge that loads the key into disp.
  assign w_key_blank = LZ_BLANK ? {w_zero_from[5:1], 1'b0} : 6'h00;

  // Snapshot edge: the counter has reached its last value.
  assign w_wrap = (r_cnt == CNT_LAST);

  // Lifecycle FSM.
  // It updates disp, the sample counter and all registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_disp   <= '0;
      r_cnt    <= '0;
      r_blank  <= BLANK_ALL;
      r_busy   <= 1'b0;
      r_found  <= 1'b0;
      r_failed <= 1'b0;
    end else begin
      case (r_state)
        // Every idle-like state restarts the same way on start.
        // done is ignored in these states.
        S_IDLE, S_FOUND, S_FAIL: begin
          if (start) begin
            r_state  <= S_RUN;
            r_disp   <= cand_key;
            r_cnt    <= '0;
            r_blank  <= 6'h00;
            r_busy   <= 1'b1;
            r_found  <= 1'b0;
            r_failed <= 1'b0;
          end
        end

        S_RUN: begin
          // done has priority over both a colliding start and a colliding snapshot.
          // start is ignored here, so the sample schedule keeps its original phase.
          if (done) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (key_valid) begin
              r_state <= S_FOUND;
              r_disp  <= key;
              r_blank <= w_key_blank;
              r_found <= 1'b1;
            end else begin
              r_state  <= S_FAIL;
              r_blank  <= BLANK_ALL;
              r_failed <= 1'b1;
            end
          end else if (w_wrap) begin
            r_disp <= cand_key;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_disp   <= '0;
          r_cnt    <= '0;
          r_blank  <= BLANK_ALL;
          r_busy   <= 1'b0;
          r_found  <= 1'b0;
          r_failed <= 1'b0;
        end
      endcase
    end
  end

  // Each digit is a direct slice of the display register. hex5 is the most significant.
  assign hex0   = r_disp[3:0];
  assign hex1   = r_disp[7:4];
  assign hex2   = r_disp[11:8];
  assign hex3   = r_disp[15:12];
  assign hex4   = r_disp[19:16];
  assign hex5   = r_disp[23:20];
  assign blank  = r_blank;
  assign busy   = r_busy;
  assign found  = r_found;
  assign failed = r_failed;

endmodule

// File: tb/tb_key_hex_driver.sv
// Testbench for key_hex_driver.
// A reference model pushes the expected display state after every clock edge.
// A separate monitor pops each entry and compares it against the DUT outputs.
module tb_key_hex_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] cand_key = 24'h0;
  logic        done = 1'b0;
  logic        key_valid = 1'b0;
  logic [23:0] key = 24'h0;
  logic [3:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [5:0]  blank;
  logic        busy, found, failed;

  typedef struct {
    logic [23:0] disp;
    logic [5:0]  blank;
    logic [2:0]  flags;  // {busy, found, failed}
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] cand_next = 24'h0;
  bit          cand_rand = 1'b0;
  bit          stim_done = 1'b0;

  key_hex_driver #(
    .SAMPLE_DIV(DIV),
    .SAMPLE_W  (4),
    .LZ_BLANK  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cand_key (cand_key),
    .done     (done),
    .key_valid(key_valid),
    .key      (key),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .blank    (blank),
    .busy     (busy),
    .found    (found),
    .failed   (failed)
  );

  always #5 clk = ~clk;

  // Blank every digit above the most significant nonzero digit.
  // Digit 0 always stays lit.
  function automatic logic [5:0] lz_mask(input logic [23:0] v);
    int          msd;
    logic [5:0]  m;
    logic [23:0] t;
    msd = -1;
    t = v;
    for (int n = 0; n < 6; n++) begin
      if (((t >> (4 * n)) & 24'hF) != 0) msd = n;
    end
    m = 6'h00;
    for (int n = 1; n < 6; n++) begin
      if (n > msd) m[n] = 1'b1;
    end
    return m;
  endfunction

  // Reference model.
  // Modes: I = idle, R = searching, F = found, X = failed.
  // Snapshots fall on every multiple of DIV cycles after the accepted start.
  initial begin
    byte         mode = "I";
    logic [23:0] disp = 24'h0;
    int          k = 0;
    int          start_cyc = 0;
    exp_t        e;
    forever begin
      @(posedge clk);
      k++;
      if (rst) begin
        mode = "I";
        disp = 24'h0;
      end else if (mode == "R") begin
        if (done) begin
          if (key_valid) begin
            mode = "F";
            disp = key;
          end else begin
            mode = "X";
          end
        end else if (((k - start_cyc) % DIV) == 0) begin
          disp = cand_key;
        end
      end else if (start) begin
        mode = "R";
        disp = cand_key;
        start_cyc = k;
      end
      e.disp  = disp;
      e.blank = (mode == "R") ? 6'h00 : (mode == "F") ? lz_mask(disp) : 6'h3F;
      e.flags = {mode == "R", mode == "F", mode == "X"};
      sb.push_back(e);
    end
  end

  // Monitor: compare one expected entry per clock, 1 time unit after the edge.
  initial begin
    exp_t        e;
    logic [23:0] act;
    int          cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act = {hex5, hex4, hex3, hex2, hex1, hex0};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d got no expectation, required one", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (act !== e.disp) begin
          errors++;
          $display("FAIL disp cyc=%0d got %h required %h", cyc, act, e.disp);
        end
        checks++;
        if (blank !== e.blank) begin
          errors++;
          $display("FAIL blank cyc=%0d got %b required %b", cyc, blank, e.blank);
        end
        checks++;
        if ({busy, found, failed} !== e.flags) begin
          errors++;
          $display("FAIL flags cyc=%0d got %b required %b", cyc, {busy, found, failed}, e.flags);
        end
        $display("cyc %0d disp=%h blank=%b flags=%b", cyc, act, blank, {busy, found, failed});
      end
    end
  end

  // Drive one cycle of inputs at the falling edge.
  // cand_key counts up by one per cycle unless random mode is on.
  task automatic cyc(input logic rs, input logic st, input logic dn,
                     input logic kv, input logic [23:0] ky);
    @(negedge clk);
    rst       = rs;
    start     = st;
    done      = dn;
    key_valid = kv;
    key       = ky;
    cand_key  = cand_rand ? 24'($urandom) : cand_next;
    cand_next = cand_next + 24'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Stimulus: directed scenarios first, then a randomized phase.
  initial begin
    logic        r_rs, r_st, r_dn, r_kv;
    logic [23:0] r_ky;
    int          sh;

    // Reset, then a done pulse in IDLE, which must be ignored.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h123456);
    idle(1);

    // Periodic sampling starting at cand_key 000010.
    // A start during RUN must not disturb the sample schedule.
    cand_next = 24'h000010;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(9);
    // This done lands on the wrap edge (start+12): the key must win over the snapshot.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h0003A7);
    idle(2);

    // Restart from FOUND, then find key 0.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000);
    idle(1);

    // Failure, then restart with cand_key 0.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'h777777);  // done in FAIL is ignored
    cand_next = 24'h000000;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(2);

    // start and done in the same RUN cycle: done wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'hABCDEF);
    idle(2);

    // Reset in the middle of RUN.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    idle(2);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      cand_rand = ($urandom_range(0, 3) == 0);
      r_rs = ($urandom_range(0, 63) == 0);
      r_st = ($urandom_range(0, 7) == 0);
      r_dn = ($urandom_range(0, 7) == 0);
      r_kv = $urandom_range(0, 1) == 1;
      sh   = $urandom_range(0, 6);
      r_ky = 24'($urandom) & (24'hFFFFFF >> (4 * sh));
      cyc(r_rs, r_st, r_dn, r_kv, r_ky);
    end
    cand_rand = 1'b0;
    idle(2);

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left, required 0", sb.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
